// File: rtl/cic_pkg.sv
// cic_pkg - shared configuration helpers for the CIC decimation filter.
// Provides the accumulator width computation, legal parameter ranges and
// the accumulator word type of the default (ORDER=3, RATE=64, M=1) build.
package cic_pkg;

    localparam int ORDER_MIN = 1;
    localparam int ORDER_MAX = 6;
    localparam int RATE_MIN  = 2;
    localparam int RATE_MAX  = 1024;

    // Full-precision word: ORDER*log2(R*M) bits of growth plus sign and headroom.
    function automatic int cic_acc_w(input int order, input int rate, input int diff_delay);
        return order * $clog2(rate * diff_delay) + 2;
    endfunction

    // True when the configuration lies inside the supported ranges.
    function automatic bit cic_cfg_ok(input int order, input int rate, input int diff_delay);
        return (order >= ORDER_MIN) && (order <= ORDER_MAX) &&
               (rate >= RATE_MIN) && (rate <= RATE_MAX) &&
               ((diff_delay == 1) || (diff_delay == 2));
    endfunction

    localparam int CIC_ACC_W_DEFAULT = cic_acc_w(3, 64, 1);

    typedef logic [CIC_ACC_W_DEFAULT-1:0] cic_acc_t;

endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage - one comb section: dout = din - din delayed by DIFF_DELAY
// decimated samples. The delay line only shifts when en (decimation strobe)
// is high; the subtraction is combinational and wraps modulo 2^ACC_W.
module cic_comb_stage #(
    parameter int ACC_W      = 20,
    parameter int DIFF_DELAY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [ACC_W-1:0] din,
    output logic [ACC_W-1:0] dout
);

    logic [ACC_W-1:0] dly_d [DIFF_DELAY];
    logic [ACC_W-1:0] dly_q [DIFF_DELAY];

    // Next state of the delay line: shift in din on the strobe, hold otherwise.
    always_comb begin
        if (en) begin
            dly_d[0] = din;
            for (int i = 1; i < DIFF_DELAY; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end else begin
            for (int i = 0; i < DIFF_DELAY; i++) begin
                dly_d[i] = dly_q[i];
            end
        end
    end

    // Delay-line registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIFF_DELAY; i++) begin
                dly_q[i] <= {ACC_W{1'b0}};
            end
        end else begin
            dly_q <= dly_d;
        end
    end

    assign dout = din - dly_q[DIFF_DELAY-1];

endmodule

// File: rtl/cic_decimator.sv
// cic_decimator - ORDER-stage CIC decimator for a 1-bit delta-sigma bitstream.
// Integrators run at the input sample rate (qualified by in_valid), a
// modulo-RATE counter produces a registered decimation strobe, and the comb
// chain is evaluated combinationally in the strobe cycle before the result is
// registered onto out with a one-cycle out_valid pulse.
// Build macro CIC_BIPOLAR_IN_EN: when defined, in=1/0 maps to +1/-1;
// otherwise in maps to the unipolar value 1/0.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int  ORDER      = 3,
    parameter int  RATE       = 64,
    parameter int  DIFF_DELAY = 1,
    localparam int ACC_W      = cic_acc_w(ORDER, RATE, DIFF_DELAY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    output logic [ACC_W-1:0] out,
    output logic             out_valid
);

    localparam int             CNT_W    = $clog2(RATE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // An out-of-range configuration never raises the strobe, so it stays silent.
    localparam bit             CFG_OK   = cic_cfg_ok(ORDER, RATE, DIFF_DELAY);

    logic [ACC_W-1:0] x_s;
    logic [ACC_W-1:0] integ_s [ORDER];
    logic [ACC_W-1:0] comb_s  [ORDER+1];

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             dec_stb_d;
    logic             dec_stb_q;
    logic [ACC_W-1:0] out_d;
    logic [ACC_W-1:0] out_q;
    logic             out_valid_d;
    logic             out_valid_q;

    // Map the modulator bit onto a full-width integrator input.
    always_comb begin
`ifdef CIC_BIPOLAR_IN_EN
        if (in) begin
            x_s = {{(ACC_W-1){1'b0}}, 1'b1};
        end else begin
            x_s = {ACC_W{1'b1}};
        end
`else
        x_s = {{(ACC_W-1){1'b0}}, in};
`endif
    end

    for (genvar k = 0; k < ORDER; k++) begin : g_integ
        logic [ACC_W-1:0] addend_s;
        logic [ACC_W-1:0] acc_d;
        logic [ACC_W-1:0] acc_q;

        if (k == 0) begin : g_first
            assign addend_s = x_s;
        end else begin : g_chain
            assign addend_s = integ_s[k-1];
        end

        // Accumulate the previous stage's registered value on each accepted sample.
        always_comb begin
            if (in_valid) begin
                acc_d = acc_q + addend_s;
            end else begin
                acc_d = acc_q;
            end
        end

        // Integrator register; wraps freely modulo 2^ACC_W.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                acc_q <= {ACC_W{1'b0}};
            end else begin
                acc_q <= acc_d;
            end
        end

        assign integ_s[k] = acc_q;
    end

    // Count accepted samples modulo RATE and request a strobe on the last one.
    always_comb begin
        cnt_d     = cnt_q;
        dec_stb_d = 1'b0;
        if (in_valid) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d     = {CNT_W{1'b0}};
                dec_stb_d = CFG_OK;
            end else begin
                cnt_d     = cnt_q + CNT_ONE;
                dec_stb_d = 1'b0;
            end
        end else begin
            cnt_d     = cnt_q;
            dec_stb_d = 1'b0;
        end
    end

    // Decimation counter and registered strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= {CNT_W{1'b0}};
            dec_stb_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dec_stb_q <= dec_stb_d;
        end
    end

    assign comb_s[0] = integ_s[ORDER-1];

    for (genvar j = 0; j < ORDER; j++) begin : g_comb
        cic_comb_stage #(
            .ACC_W      (ACC_W),
            .DIFF_DELAY (DIFF_DELAY)
        ) u_comb (
            .clk   (clk),
            .rst_n (rst),
            .en    (dec_stb_q),
            .din   (comb_s[j]),
            .dout  (comb_s[j+1])
        );
    end

    // Capture the comb result on the strobe and hold it between pulses.
    always_comb begin
        out_valid_d = dec_stb_q;
        if (dec_stb_q) begin
            out_d = comb_s[ORDER];
        end else begin
            out_d = out_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q       <= {ACC_W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule
